// File: rtl/uart2wb_burst.sv
// uart2wb_burst: ASCII-command UART to Wishbone bridge with burst reads,
// write acknowledge and bus timeout.
//
// Commands: a/d/c select ADDR/DATA/CNT, uppercase hex digits shift into the
// selected register, 'w' writes DATA to ADDR, 'r' reads CNT+1 words starting at
// ADDR and returns them as hex followed by LF, '.' aborts and pulses o_reset.
module uart2wb_burst #(
  parameter int AW      = 24,
  parameter int DW      = 8,
  parameter int TIMEOUT = 255
) (
  input  logic          i_wb_clk,
  input  logic          i_wb_rst,
  input  logic          i_wb_ack,
  input  logic [DW-1:0] i_wb_dat,
  output logic [DW-1:0] o_wb_dat,
  output logic [AW-1:0] o_wb_addr,
  output logic          o_wb_stb,
  output logic          o_wb_cyc,
  output logic          o_wb_we,
  input  logic [7:0]    uart_rx_dat,
  input  logic          uart_received_strobe,
  output logic [7:0]    uart_tx_dat,
  output logic          uart_tx_trigger,
  input  logic          uart_tx_ready,
  output logic          o_reset,
  output logic          o_busy
);

  localparam int          NIB      = DW / 4;
  localparam logic [3:0]  NIB_LAST = 4'(NIB - 1);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  localparam logic [7:0] CH_ABORT = 8'h2E;
  localparam logic [7:0] CH_SELA  = 8'h61;  // 'a'
  localparam logic [7:0] CH_SELD  = 8'h64;  // 'd'
  localparam logic [7:0] CH_SELC  = 8'h63;  // 'c'
  localparam logic [7:0] CH_WR    = 8'h77;  // 'w'
  localparam logic [7:0] CH_RD    = 8'h72;  // 'r'
  localparam logic [7:0] CH_ACK   = 8'h4B;  // 'K'
  localparam logic [7:0] CH_TMO   = 8'h21;  // '!'
  localparam logic [7:0] CH_LF    = 8'h0A;

  typedef enum logic [2:0] {IDLE, WB_WR, WB_RD, TX_HEX, TX_TERM} state_t;
  typedef enum logic [1:0] {SEL_ADDR, SEL_DATA, SEL_CNT} sel_t;

  state_t        state_q, state_d;
  sel_t          sel_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;
  logic [7:0]    cnt_q;
  logic [7:0]    rd_left_q;  // words still to read after the current one
  logic [DW-1:0] word_q;     // read word, shifted left as nibbles go out
  logic [3:0]    nib_q;
  logic [7:0]    term_q;     // queued terminating character
  logic [15:0]   tmo_q;
  logic          gap_q;      // forces an idle cycle after every trigger
  logic          rst_q;

  logic          rx_abort, rx_cmd, hex_vld, ack, tmo_hit, tx_trig, last_nib;
  logic [3:0]    hex_nib;
  logic [4:0]    hex_dec_w;

  // Uppercase hex digit decode: {valid, nibble}
  function automatic logic [4:0] hex_dec(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39)      return {1'b1, c[3:0]};
    else if (c >= 8'h41 && c <= 8'h46) return {1'b1, 4'(c[3:0] + 4'd9)};
    else                               return 5'b0;
  endfunction

  // Nibble to uppercase ASCII hex
  function automatic logic [7:0] hex_enc(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

  assign hex_dec_w = hex_dec(uart_rx_dat);
  assign hex_vld   = hex_dec_w[4];
  assign hex_nib   = hex_dec_w[3:0];

  assign rx_abort = uart_received_strobe && (uart_rx_dat == CH_ABORT);
  assign rx_cmd   = uart_received_strobe && (state_q == IDLE);

  // Strobe is a pure state decode so it follows the state register exactly
  assign o_wb_stb = (state_q == WB_WR) || (state_q == WB_RD);
  assign o_wb_cyc = o_wb_stb;
  assign o_wb_we  = (state_q == WB_WR);
  assign o_wb_addr = addr_q;
  assign o_wb_dat  = data_q;
  assign o_busy    = (state_q != IDLE);
  assign o_reset   = rst_q;

  assign ack      = o_wb_stb && i_wb_ack;
  assign tmo_hit  = o_wb_stb && !i_wb_ack && (tmo_q == TMO_LAST);
  assign last_nib = (nib_q == NIB_LAST);

  // Trigger only when the transmitter is ready; an abort in the same cycle
  // discards the pending character
  assign tx_trig = ((state_q == TX_HEX) || (state_q == TX_TERM)) &&
                   uart_tx_ready && !gap_q && !rx_abort;

  // Character presented alongside the trigger
  always_comb begin
    uart_tx_dat = 8'h00;
    if (state_q == TX_HEX)       uart_tx_dat = hex_enc(word_q[DW-1 -: 4]);
    else if (state_q == TX_TERM) uart_tx_dat = term_q;
  end

  assign uart_tx_trigger = tx_trig;

  // State register
  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; abort overrides everything
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (rx_cmd && uart_rx_dat == CH_WR)      state_d = WB_WR;
        else if (rx_cmd && uart_rx_dat == CH_RD) state_d = WB_RD;
      end
      WB_WR:   if (ack || tmo_hit) state_d = TX_TERM;
      WB_RD: begin
        if (ack)          state_d = TX_HEX;
        else if (tmo_hit) state_d = TX_TERM;
      end
      TX_HEX: begin
        if (tx_trig && last_nib) state_d = (rd_left_q != 8'd0) ? WB_RD : TX_TERM;
      end
      TX_TERM: if (tx_trig) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (rx_abort) state_d = IDLE;
  end

  // Registers, selector, read/hex sequencing and queued terminator
  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      sel_q     <= SEL_ADDR;
      addr_q    <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      rd_left_q <= '0;
      word_q    <= '0;
      nib_q     <= '0;
      term_q    <= '0;
    end else if (rx_abort) begin
      sel_q <= SEL_ADDR;
    end else begin
      case (state_q)
        IDLE: if (rx_cmd) begin
          if (uart_rx_dat == CH_SELA)      sel_q <= SEL_ADDR;
          else if (uart_rx_dat == CH_SELD) sel_q <= SEL_DATA;
          else if (uart_rx_dat == CH_SELC) sel_q <= SEL_CNT;
          else if (uart_rx_dat == CH_RD)   rd_left_q <= cnt_q;
          else if (hex_vld) begin
            case (sel_q)
              SEL_ADDR: addr_q <= AW'({addr_q, hex_nib});
              SEL_DATA: data_q <= DW'({data_q, hex_nib});
              default:  cnt_q  <= 8'({cnt_q, hex_nib});
            endcase
          end
        end
        WB_WR: begin
          if (ack) begin
            addr_q <= addr_q + AW'(1);
            term_q <= CH_ACK;
          end else if (tmo_hit) begin
            term_q <= CH_TMO;
          end
        end
        WB_RD: begin
          if (ack) begin
            word_q <= i_wb_dat;
            addr_q <= addr_q + AW'(1);
            nib_q  <= '0;
          end else if (tmo_hit) begin
            term_q <= CH_TMO;
          end
        end
        TX_HEX: if (tx_trig) begin
          word_q <= word_q << 4;
          nib_q  <= nib_q + 4'd1;
          if (last_nib) begin
            if (rd_left_q != 8'd0) rd_left_q <= rd_left_q - 8'd1;
            else                   term_q    <= CH_LF;
          end
        end
        default: ;
      endcase
    end
  end

  // Bus timeout counter: counts strobe cycles without acknowledge
  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst)                 tmo_q <= '0;
    else if (!o_wb_stb || ack)    tmo_q <= '0;
    else                          tmo_q <= tmo_q + 16'd1;
  end

  // Transmit spacing and one-cycle reset pulse
  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      gap_q <= 1'b0;
      rst_q <= 1'b0;
    end else begin
      gap_q <= tx_trig;
      rst_q <= rx_abort;
    end
  end

endmodule

// File: tb/tb_uart2wb_burst.sv
// Directed bench for uart2wb_burst: write, burst read with wrap, tx stall,
// timeout, mid-burst abort and asynchronous reset.
module tb_uart2wb_burst;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_ack = 1'b0;
  logic [7:0]  wb_rdat = 8'h00;
  logic [7:0]  o_wb_dat;
  logic [23:0] o_wb_addr;
  logic        o_wb_stb, o_wb_cyc, o_wb_we;
  logic [7:0]  rx_dat = 8'h00;
  logic        rx_stb = 1'b0;
  logic [7:0]  tx_dat;
  logic        tx_trig;
  logic        tx_ready = 1'b1;
  logic        o_reset, o_busy;

  uart2wb_burst #(.AW(24), .DW(8), .TIMEOUT(255)) dut (
    .i_wb_clk(clk), .i_wb_rst(rst), .i_wb_ack(wb_ack), .i_wb_dat(wb_rdat),
    .o_wb_dat(o_wb_dat), .o_wb_addr(o_wb_addr), .o_wb_stb(o_wb_stb),
    .o_wb_cyc(o_wb_cyc), .o_wb_we(o_wb_we), .uart_rx_dat(rx_dat),
    .uart_received_strobe(rx_stb), .uart_tx_dat(tx_dat),
    .uart_tx_trigger(tx_trig), .uart_tx_ready(tx_ready),
    .o_reset(o_reset), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [23:0] a; logic [7:0] d; logic we; } wb_t;

  int         vecs = 0;
  int         errs = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rd_q[$];
  wb_t        wb_log[$];
  int         stb_cycles = 0;
  int         rst_pulses = 0;
  int         tx_viol = 0;
  logic       prev_trig = 1'b0;
  int         slv_delay = 0;
  bit         slv_en = 1'b1;
  int         wcnt = 0;

  // Slave: acks after slv_delay strobe cycles, returns words from rd_q
  always @(negedge clk) begin
    if (o_wb_stb && !wb_ack && slv_en) begin
      if (wcnt >= slv_delay) begin
        wb_ack = 1'b1;
        wcnt = 0;
        if (!o_wb_we) wb_rdat = (rd_q.size() > 0) ? rd_q.pop_front() : 8'h00;
        wb_log.push_back('{o_wb_addr, o_wb_we ? o_wb_dat : wb_rdat, o_wb_we});
      end else wcnt++;
    end else begin
      wb_ack = 1'b0;
      if (!o_wb_stb) wcnt = 0;
    end
  end

  // Monitor: collects transmitted chars, checks tx handshake rules
  always @(negedge clk) begin
    if (o_wb_stb) stb_cycles++;
    if (tx_trig) begin
      if (!tx_ready || prev_trig) tx_viol++;
      tx_q.push_back(tx_dat);
    end
    prev_trig = tx_trig;
    if (o_reset) rst_pulses++;
  end

  function automatic string tx_str();
    string s = "";
    foreach (tx_q[i]) s = (tx_q[i] == 8'h0A) ? {s, "\\n"} : $sformatf("%s%c", s, tx_q[i]);
    return s;
  endfunction

  task automatic send_char(input logic [7:0] c);
    rx_dat = c; rx_stb = 1'b1;
    @(posedge clk); #1;
    rx_stb = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while (o_busy && n < maxc) begin @(posedge clk); #1; n++; end
    vecs++; if (o_busy) begin errs++; $display("FAIL idle_wait busy=%b after %0d cycles", o_busy, n); end
  endtask

  task automatic clear_logs();
    tx_q.delete(); wb_log.delete(); rd_q.delete();
  endtask

  task automatic test_reset();
    #2;
    vecs++; if (o_wb_stb !== 1'b0) begin errs++; $display("FAIL rst_stb got %b want 0", o_wb_stb); end
    vecs++; if (o_wb_cyc !== 1'b0) begin errs++; $display("FAIL rst_cyc got %b want 0", o_wb_cyc); end
    vecs++; if (o_wb_we !== 1'b0) begin errs++; $display("FAIL rst_we got %b want 0", o_wb_we); end
    vecs++; if (tx_trig !== 1'b0) begin errs++; $display("FAIL rst_trig got %b want 0", tx_trig); end
    vecs++; if (o_reset !== 1'b0) begin errs++; $display("FAIL rst_reset got %b want 0", o_reset); end
    vecs++; if (o_busy !== 1'b0) begin errs++; $display("FAIL rst_busy got %b want 0", o_busy); end
    vecs++; if (o_wb_addr !== 24'h0) begin errs++; $display("FAIL rst_addr got %h want 000000", o_wb_addr); end
    vecs++; if (o_wb_dat !== 8'h0) begin errs++; $display("FAIL rst_dat got %h want 00", o_wb_dat); end
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write();
    clear_logs(); slv_delay = 3;
    send_str("a12345Fd9Cw");
    wait_idle(200);
    vecs++; if (wb_log.size() !== 1) begin errs++; $display("FAIL wr_count got %0d want 1", wb_log.size()); end
    if (wb_log.size() > 0) begin
      vecs++; if (wb_log[0].a !== 24'h12345F) begin errs++; $display("FAIL wr_addr got %h want 12345F", wb_log[0].a); end
      vecs++; if (wb_log[0].d !== 8'h9C) begin errs++; $display("FAIL wr_dat got %h want 9C", wb_log[0].d); end
      vecs++; if (wb_log[0].we !== 1'b1) begin errs++; $display("FAIL wr_we got %b want 1", wb_log[0].we); end
    end
    vecs++; if (tx_str() != "K") begin errs++; $display("FAIL wr_tx got '%s' want 'K'", tx_str()); end
    vecs++; if (o_wb_addr !== 24'h123460) begin errs++; $display("FAIL wr_addr_inc got %h want 123460", o_wb_addr); end
  endtask

  task automatic test_burst_wrap();
    clear_logs(); slv_delay = 1;
    rd_q.push_back(8'hA1); rd_q.push_back(8'hB2); rd_q.push_back(8'hC3);
    send_str("c2aFFFFFEr");
    wait_idle(500);
    vecs++; if (wb_log.size() !== 3) begin errs++; $display("FAIL burst_count got %0d want 3", wb_log.size()); end
    if (wb_log.size() == 3) begin
      vecs++; if (wb_log[0].a !== 24'hFFFFFE) begin errs++; $display("FAIL burst_a0 got %h want FFFFFE", wb_log[0].a); end
      vecs++; if (wb_log[1].a !== 24'hFFFFFF) begin errs++; $display("FAIL burst_a1 got %h want FFFFFF", wb_log[1].a); end
      vecs++; if (wb_log[2].a !== 24'h000000) begin errs++; $display("FAIL burst_a2 got %h want 000000", wb_log[2].a); end
      vecs++; if (wb_log[1].we !== 1'b0) begin errs++; $display("FAIL burst_we got %b want 0", wb_log[1].we); end
    end
    vecs++; if (tx_str() != "A1B2C3\\n") begin errs++; $display("FAIL burst_tx got '%s' want 'A1B2C3\\n'", tx_str()); end
    vecs++; if (o_wb_addr !== 24'h000001) begin errs++; $display("FAIL burst_addr got %h want 000001", o_wb_addr); end
  endtask

  task automatic test_tx_stall();
    int n = 0;
    int n0;
    clear_logs(); slv_delay = 0;
    rd_q.push_back(8'h5A); rd_q.push_back(8'h6B); rd_q.push_back(8'h7C);
    send_char("r");
    while (tx_q.size() < 1 && n < 100) begin @(posedge clk); #1; n++; end
    tx_ready = 1'b0;
    n0 = tx_q.size();
    repeat (20) @(posedge clk);
    #1;
    vecs++; if (tx_q.size() !== n0) begin errs++; $display("FAIL stall_tx got %0d chars want %0d", tx_q.size(), n0); end
    vecs++; if (o_busy !== 1'b1) begin errs++; $display("FAIL stall_busy got %b want 1", o_busy); end
    tx_ready = 1'b1;
    wait_idle(500);
    vecs++; if (tx_str() != "5A6B7C\\n") begin errs++; $display("FAIL stall_order got '%s' want '5A6B7C\\n'", tx_str()); end
    vecs++; if (tx_viol !== 0) begin errs++; $display("FAIL tx_handshake got %0d violations want 0", tx_viol); end
    vecs++; if (o_wb_addr !== 24'h000004) begin errs++; $display("FAIL stall_addr got %h want 000004", o_wb_addr); end
  endtask

  task automatic test_timeout();
    clear_logs(); slv_en = 1'b0; stb_cycles = 0;
    send_char("r");
    wait_idle(400);
    vecs++; if (stb_cycles !== 255) begin errs++; $display("FAIL tmo_stb_cycles got %0d want 255", stb_cycles); end
    vecs++; if (tx_str() != "!") begin errs++; $display("FAIL tmo_tx got '%s' want '!'", tx_str()); end
    vecs++; if (o_wb_addr !== 24'h000004) begin errs++; $display("FAIL tmo_addr got %h want 000004", o_wb_addr); end
    vecs++; if (o_wb_stb !== 1'b0) begin errs++; $display("FAIL tmo_stb got %b want 0", o_wb_stb); end
    slv_en = 1'b1;
  endtask

  task automatic test_abort();
    int n = 0;
    clear_logs(); slv_delay = 2; rst_pulses = 0;
    rd_q.push_back(8'h3D);
    send_str("dr");
    while (wb_log.size() < 1 && n < 100) begin @(posedge clk); #1; n++; end
    slv_delay = 200;
    n = 0;
    while (!o_wb_stb && n < 100) begin @(posedge clk); #1; n++; end
    vecs++; if (o_wb_stb !== 1'b1) begin errs++; $display("FAIL abort_pre_stb got %b want 1", o_wb_stb); end
    rx_dat = 8'h2E; rx_stb = 1'b1;
    @(posedge clk); #1;
    rx_stb = 1'b0;
    vecs++; if (o_reset !== 1'b1) begin errs++; $display("FAIL abort_reset got %b want 1", o_reset); end
    vecs++; if (o_wb_stb !== 1'b0) begin errs++; $display("FAIL abort_stb got %b want 0", o_wb_stb); end
    vecs++; if (o_busy !== 1'b0) begin errs++; $display("FAIL abort_busy got %b want 0", o_busy); end
    @(posedge clk); #1;
    vecs++; if (o_reset !== 1'b0) begin errs++; $display("FAIL abort_reset_width got %b want 0", o_reset); end
    repeat (20) @(posedge clk);
    #1;
    vecs++; if (rst_pulses !== 1) begin errs++; $display("FAIL abort_pulses got %0d want 1", rst_pulses); end
    vecs++; if (tx_str() != "3D") begin errs++; $display("FAIL abort_tx got '%s' want '3D'", tx_str()); end
    vecs++; if (o_wb_addr !== 24'h000005) begin errs++; $display("FAIL abort_addr got %h want 000005", o_wb_addr); end
    vecs++; if (o_wb_dat !== 8'h9C) begin errs++; $display("FAIL abort_dat got %h want 9C", o_wb_dat); end
    send_char("7");
    vecs++; if (o_wb_addr !== 24'h000057) begin errs++; $display("FAIL abort_sel got %h want 000057", o_wb_addr); end
  endtask

  task automatic test_cnt_retained();
    clear_logs(); slv_delay = 0;
    rd_q.push_back(8'h11); rd_q.push_back(8'h22); rd_q.push_back(8'h33);
    send_char("r");
    wait_idle(500);
    vecs++; if (wb_log.size() !== 3) begin errs++; $display("FAIL cnt_count got %0d want 3", wb_log.size()); end
    if (wb_log.size() == 3) begin
      vecs++; if (wb_log[2].a !== 24'h000059) begin errs++; $display("FAIL cnt_a2 got %h want 000059", wb_log[2].a); end
    end
    vecs++; if (tx_str() != "112233\\n") begin errs++; $display("FAIL cnt_tx got '%s' want '112233\\n'", tx_str()); end
  endtask

  task automatic test_async_reset();
    clear_logs(); slv_en = 1'b0;
    send_char("w");
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    vecs++; if (o_wb_stb !== 1'b0) begin errs++; $display("FAIL arst_stb got %b want 0", o_wb_stb); end
    vecs++; if (o_wb_we !== 1'b0) begin errs++; $display("FAIL arst_we got %b want 0", o_wb_we); end
    vecs++; if (o_wb_cyc !== 1'b0) begin errs++; $display("FAIL arst_cyc got %b want 0", o_wb_cyc); end
    vecs++; if (o_busy !== 1'b0) begin errs++; $display("FAIL arst_busy got %b want 0", o_busy); end
    vecs++; if (o_wb_addr !== 24'h0) begin errs++; $display("FAIL arst_addr got %h want 000000", o_wb_addr); end
    vecs++; if (o_wb_dat !== 8'h0) begin errs++; $display("FAIL arst_dat got %h want 00", o_wb_dat); end
    @(posedge clk); #1;
    rst = 1'b0; slv_en = 1'b1; slv_delay = 0;
    clear_logs();
    rd_q.push_back(8'hEE); rd_q.push_back(8'hFF);
    @(posedge clk); #1;
    send_char("r");
    wait_idle(300);
    vecs++; if (wb_log.size() !== 1) begin errs++; $display("FAIL arst_cnt got %0d words want 1", wb_log.size()); end
    vecs++; if (tx_str() != "EE\\n") begin errs++; $display("FAIL arst_tx got '%s' want 'EE\\n'", tx_str()); end
    vecs++; if (o_wb_addr !== 24'h000001) begin errs++; $display("FAIL arst_addr_inc got %h want 000001", o_wb_addr); end
  endtask

  initial begin
    @(posedge clk); @(posedge clk); #1;
    test_reset();
    test_write();
    test_burst_wrap();
    test_tx_stall();
    test_timeout();
    test_abort();
    test_cnt_retained();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
